// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic dot-product engine: FSM encoding, multiply-mode
// constants and a width helper that never returns zero.
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MODE_UNIPOLAR = 0;
    localparam int MODE_BIPOLAR  = 1;

    // $clog2 yields 0 for 1 and 1 for 2; an index bus still needs at least one bit.
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sc_dot_product_engine_if.sv
// Stream and run-control bundle between the SNG/RNG front end (master) and the engine (slave).
interface sc_dot_product_engine_if
    import sc_pkg::*;
#(
    parameter int LENGTH     = 3,
    parameter int NUM_OUT    = 2,
    parameter int STREAM_LEN = 256
) ();
    localparam int SEL_W = clog2_safe(LENGTH);
    localparam int CNT_W = $clog2(STREAM_LEN + 1);

    logic                       start;
    logic                       in_valid;
    logic [LENGTH-1:0]          data;
    logic [NUM_OUT*LENGTH-1:0]  weights;
    logic [SEL_W-1:0]           sel;
    logic                       busy;
    logic                       done;
    logic [NUM_OUT-1:0]         sum;
    logic                       sum_valid;
    logic [NUM_OUT*CNT_W-1:0]   counts;

    modport master (
        output start, in_valid, data, weights, sel,
        input  busy, done, sum, sum_valid, counts
    );

    modport slave (
        input  start, in_valid, data, weights, sel,
        output busy, done, sum, sum_valid, counts
    );
endinterface

// File: rtl/sc_stream_counter.sv
// Counts 1s on a stochastic stream; clr restarts a run, en qualifies each bit.
module sc_stream_counter #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en && bit_in) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/sc_dot_product_engine.sv
// NUM_OUT stochastic dot products sharing one data stream: AND/XNOR multiply, mux-based scaled
// add selected by an external RNG index, and per-neuron 1s counters framed by start/busy/done.
module sc_dot_product_engine
    import sc_pkg::*;
#(
    parameter int LENGTH     = 3,
    parameter int NUM_OUT    = 2,
    parameter int STREAM_LEN = 256,
    parameter int BIPOLAR    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    sc_dot_product_engine_if.slave   bus
);
    localparam int SEL_W = clog2_safe(LENGTH);
    localparam int CNT_W = $clog2(STREAM_LEN + 1);

    state_t                           state_reg, state_next;
    logic [CNT_W-1:0]                 acc_cnt_reg;
    logic                             accept, last_accept, start_run;
    logic [NUM_OUT-1:0][LENGTH-1:0]   prod_next, prod_reg;
    logic [SEL_W-1:0]                 sel_q_reg;
    logic                             valid_q_reg;
    logic [NUM_OUT-1:0]               mux_vec;
    logic [NUM_OUT-1:0]               sum_reg;
    logic                             sum_valid_reg;
    logic [NUM_OUT-1:0][CNT_W-1:0]    count_arr;
    logic                             busy_c, done_c;

    assign start_run   = (state_reg == ST_IDLE) && bus.start;
    assign accept      = (state_reg == ST_RUN) && bus.in_valid;
    assign last_accept = accept && (acc_cnt_reg == CNT_W'(STREAM_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN holds until the last accepted bit has left stage 1, so counts are final at DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.start)   state_next = ST_RUN;
            ST_RUN:   if (last_accept) state_next = ST_DRAIN;
            ST_DRAIN: if (!valid_q_reg) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_reg)
            ST_RUN, ST_DRAIN: busy_c = 1'b1;
            ST_DONE:          done_c = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            acc_cnt_reg <= '0;
        end else if (accept) begin
            acc_cnt_reg <= acc_cnt_reg + 1'b1;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_neuron
            for (gj = 0; gj < LENGTH; gj++) begin : g_elem
                if (BIPOLAR == MODE_BIPOLAR) begin : g_xnor
                    assign prod_next[gi][gj] = ~(bus.data[gj] ^ bus.weights[gi*LENGTH + gj]);
                end else begin : g_and
                    assign prod_next[gi][gj] = bus.data[gj] & bus.weights[gi*LENGTH + gj];
                end
            end

            // Out-of-range indices match no element and contribute a 0 bit.
            logic mux_bit;
            always_comb begin
                mux_bit = 1'b0;
                for (int i = 0; i < LENGTH; i++) begin
                    if (sel_q_reg == SEL_W'(i)) mux_bit = prod_reg[gi][i];
                end
            end
            assign mux_vec[gi] = mux_bit;

            sc_stream_counter #(
                .CNT_W (CNT_W)
            ) u_counter (
                .clk    (clk),
                .rst    (rst),
                .clr    (start_run),
                .en     (valid_q_reg),
                .bit_in (mux_vec[gi]),
                .count  (count_arr[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg    <= '0;
            sel_q_reg   <= '0;
            valid_q_reg <= 1'b0;
        end else begin
            valid_q_reg <= accept;
            if (accept) begin
                prod_reg  <= prod_next;
                sel_q_reg <= bus.sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg       <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            sum_reg       <= mux_vec;
            sum_valid_reg <= valid_q_reg;
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.sum       = sum_reg;
    assign bus.sum_valid = sum_valid_reg;
    assign bus.counts    = count_arr;
endmodule
